// File: rtl/seq_divider_if.sv
// seq_divider_if: request/response bundle for the sequential divider.
//
// Handshake rule, for both directions: a transfer happens on a rising clk
// edge where valid and ready are both high. A valid source keeps valid and
// its payload steady until that edge; ready may change freely.
//
//   start_valid / start_ready / dividend / divisor : request channel
//   out_valid / out_ready / quotient / remainder / div_by_zero : response
//   busy : divider is computing or holding an unconsumed result
//
// master: the requester/consumer side; slave: the divider.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output start_valid, dividend, divisor, out_ready,
        input  start_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  start_valid, dividend, divisor, out_ready,
        output start_ready, out_valid, quotient, remainder, div_by_zero, busy
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per
// clock. Trial subtraction uses a carry-lookahead adder computing
// {R, next dividend bit} + ~{0, divisor} + 1; carry-out 1 means no borrow.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        seq_divider_if.slave (request, response, busy)
//   dbg_state  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Timing: a normal divide raises out_valid WIDTH edges after the acceptance
// edge; a zero divisor goes straight to DONE on the acceptance edge.
// After a result is consumed, start_ready returns one cycle later, so a
// request never overlaps a completing result.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd_sh;   // dividend bits shift out at MSB, quotient bits enter at LSB
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] rem;      // partial remainder, always < divisor

    logic             start_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;

    // Carry-lookahead add: every carry is formed directly from generate /
    // propagate terms and the carry-in rather than from the previous carry.
    function automatic logic [WIDTH+1:0] cla_add(
        input logic [WIDTH:0] a,
        input logic [WIDTH:0] b,
        input logic           cin
    );
        logic [WIDTH:0]   g;
        logic [WIDTH:0]   p;
        logic [WIDTH+1:0] c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i <= WIDTH; i++) begin
            logic any_gen;
            logic all_prop;
            any_gen  = 1'b0;
            all_prop = cin;
            for (int j = 0; j <= i; j++) begin
                logic run;
                run = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    run = run & p[k];
                end
                any_gen  = any_gen | run;
                all_prop = all_prop & p[j];
            end
            c[i+1] = any_gen | all_prop;
        end
        return {c[WIDTH+1], p ^ c[WIDTH:0]};
    endfunction

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] add_res;
    logic             no_borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;

    always_comb begin
        trial     = {rem, dvd_sh[WIDTH-1]};
        add_res   = cla_add(trial, ~{1'b0, dvs}, 1'b1);
        no_borrow = add_res[WIDTH+1];
        rem_next  = no_borrow ? add_res[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next    = {dvd_sh[WIDTH-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            dvd_sh        <= '0;
            dvs           <= '0;
            rem           <= '0;
            start_ready_r <= 1'b1;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            quotient_r    <= '0;
            remainder_r   <= '0;
            dbz_r         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ready_r && bus.start_valid) begin
                        start_ready_r <= 1'b0;
                        busy_r        <= 1'b1;
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                            dbz_r       <= 1'b1;
                            out_valid_r <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvd_sh <= bus.dividend;
                            dvs    <= bus.divisor;
                            rem    <= '0;
                            count  <= CW'(WIDTH);
                            state  <= CALC;
                        end
                    end else begin
                        // Re-arms one cycle after returning from DONE.
                        start_ready_r <= 1'b1;
                    end
                end
                CALC: begin
                    rem    <= rem_next;
                    dvd_sh <= q_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        quotient_r  <= q_next;
                        remainder_r <= rem_next;
                        dbz_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.busy        = busy_r;
    assign bus.quotient    = quotient_r;
    assign bus.remainder   = remainder_r;
    assign bus.div_by_zero = dbz_r;
    assign dbg_state       = state;
endmodule
